// File: rtl/shift_ser_ctrl_pkg.sv
// Shared types and constants for the byte serializer controller.
// Optional parity state is present only when SHIFT_SER_CTRL_PARITY_EN is defined.
package shift_ser_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
`ifdef SHIFT_SER_CTRL_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_GAP    = 3'd4
    } state_t;

endpackage

// File: rtl/shift_ser_ctrl.sv
// Serializer controller: drives an external 8-bit shift register and emits one bit per cycle.
// Define SHIFT_SER_CTRL_PARITY_EN to append an even-parity bit after the 8 data bits.
module shift_ser_ctrl
    import shift_ser_ctrl_pkg::*;
#(
    parameter int IDLE_GAP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              lsb_first,
    output logic              in_ready,
    input  logic              abort,
    output logic              sr_load,
    output logic              sr_shift,
    output logic              sr_dir,
    output logic [DATA_W-1:0] sr_data,
    output logic              sr_ser_in,
    input  logic [DATA_W-1:0] sr_q,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              busy,
    output logic              done
);

    localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [GAP_W-1:0]   gap_reg, gap_next;
    logic [DATA_W-1:0]  data_reg;
    logic               lsb_reg;
    state_t             after_frame;

    // Only the two end bits of the register are ever observed as the serial tap.
    logic unused_sr_bits;
    assign unused_sr_bits = ^sr_q[DATA_W-2:1];

    assign after_frame = (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            gap_reg   <= '0;
            data_reg  <= '0;
            lsb_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            gap_reg   <= gap_next;
            if (state_reg == ST_IDLE && in_valid && !abort) begin
                data_reg <= in_data;
                lsb_reg  <= lsb_first;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        gap_next   = gap_reg;
        in_ready   = 1'b0;
        busy       = 1'b1;
        sr_load    = 1'b0;
        sr_shift   = 1'b0;
        sr_dir     = 1'b0;
        sr_data    = '0;
        sr_ser_in  = 1'b0;
        bit_out    = 1'b0;
        bit_valid  = 1'b0;
        done       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                cnt_next = '0;
                // A simultaneous abort blocks the handshake.
                if (in_valid && !abort) begin
                    state_next = ST_LOAD;
                end
            end

            ST_LOAD: begin
                sr_load  = 1'b1;
                sr_data  = data_reg;
                cnt_next = '0;
                state_next = abort ? ST_IDLE : ST_SHIFT;
            end

            ST_SHIFT: begin
                sr_shift  = 1'b1;
                sr_dir    = lsb_reg;
                bit_valid = 1'b1;
                bit_out   = lsb_reg ? sr_q[0] : sr_q[DATA_W-1];
                cnt_next  = cnt_reg + 1'b1;
                if (abort) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
`ifdef SHIFT_SER_CTRL_PARITY_EN
                    state_next = ST_PARITY;
`else
                    done       = 1'b1;
                    gap_next   = '0;
                    state_next = after_frame;
`endif
                end
            end

`ifdef SHIFT_SER_CTRL_PARITY_EN
            ST_PARITY: begin
                bit_valid = 1'b1;
                bit_out   = ^data_reg;
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    done       = 1'b1;
                    gap_next   = '0;
                    state_next = after_frame;
                end
            end
`endif

            ST_GAP: begin
                if (gap_reg == GAP_LAST) begin
                    gap_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    gap_next = gap_reg + 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_ser_ctrl.sv
// Self-checking bench for shift_ser_ctrl with a behavioural shift register alongside it.
// Expected bits are derived directly from the byte value and the requested bit order.
module tb_shift_ser_ctrl;

`ifdef SHIFT_SER_CTRL_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       lsb_first = 1'b0;
    logic       abort = 1'b0;
    logic       in_ready, sr_load, sr_shift, sr_dir, sr_ser_in;
    logic [7:0] sr_data, sr_q;
    logic       bit_out, bit_valid, busy, done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_ser_ctrl #(.IDLE_GAP(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .lsb_first (lsb_first),
        .in_ready  (in_ready),
        .abort     (abort),
        .sr_load   (sr_load),
        .sr_shift  (sr_shift),
        .sr_dir    (sr_dir),
        .sr_data   (sr_data),
        .sr_ser_in (sr_ser_in),
        .sr_q      (sr_q),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .busy      (busy),
        .done      (done)
    );

    // External shift register: dir 0 shifts left, dir 1 shifts right.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           sr_q <= 8'h00;
        else if (sr_load)  sr_q <= sr_data;
        else if (sr_shift) sr_q <= sr_dir ? {sr_ser_in, sr_q[7:1]} : {sr_q[6:0], sr_ser_in};
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input logic lsb, input int i);
        return lsb ? b[i] : b[7-i];
    endfunction

    // Sends one byte and checks every cycle of the frame; optional hold/abort/reset injection.
    task automatic send_frame(input logic [7:0] b, input logic lsb, input logic keep,
                              input logic [7:0] nb, input int abort_at, input int rst_at);
        int waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", {7'b0, in_ready}, 8'h01);
        in_valid  = 1'b1;
        in_data   = b;
        lsb_first = lsb;
        @(negedge clk);
        check("load_strobes", {6'b0, sr_shift, sr_load}, 8'h01);
        check("load_data", sr_data, b);
        check("load_flags", {5'b0, in_ready, busy, bit_valid}, 8'h02);
        if (keep) in_data = nb;
        else      in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("bit_valid", {7'b0, bit_valid}, 8'h01);
            check("bit", {7'b0, bit_out}, {7'b0, exp_bit(b, lsb, i)});
            check("shift_strobes", {5'b0, sr_load, sr_shift, sr_dir}, {5'b0, 2'b01, lsb});
            check("shift_flags", {6'b0, in_ready, busy}, 8'h01);
            check("done", {7'b0, done}, {7'b0, (!PAR && i == 7)});
            if (i == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check("abort_out", {4'b0, bit_valid, done, busy, in_ready}, 8'h01);
                return;
            end
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_out", {1'b0, bit_valid, done, busy, in_ready, sr_load, sr_shift, bit_out}, 8'h08);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
        if (PAR) begin
            @(negedge clk);
            check("parity_bit", {7'b0, bit_out}, {7'b0, ^b});
            check("parity_flags", {5'b0, bit_valid, done, sr_shift}, 8'h06);
        end
        @(negedge clk);
        check("gap", {2'b0, bit_valid, done, busy, in_ready, sr_load, sr_shift}, 8'h08);
        @(negedge clk);
        check("idle_again", {6'b0, in_ready, busy}, 8'h02);
    endtask

    initial begin
        logic [7:0] rb;
        logic       rl;
        #2;
        check("reset_state", {1'b0, sr_load, sr_shift, bit_out, bit_valid, busy, done, in_ready}, 8'h01);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        send_frame(8'hB2, 1'b0, 1'b0, 8'h00, -1, -1);
        send_frame(8'hB2, 1'b1, 1'b0, 8'h00, -1, -1);
        send_frame(8'h07, 1'b0, 1'b0, 8'h00, -1, -1);

        // Back-to-back with in_valid held: second byte must wait out the gap.
        send_frame(8'h55, 1'b0, 1'b1, 8'h3C, -1, -1);
        check("held_valid", {7'b0, in_valid}, 8'h01);
        send_frame(8'h3C, 1'b0, 1'b0, 8'h00, -1, -1);

        send_frame(8'hFF, 1'b0, 1'b0, 8'h00, 3, -1);
        send_frame(8'h5A, 1'b1, 1'b0, 8'h00, -1, -1);

        // Abort together with a handshake in IDLE blocks the handshake.
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        @(negedge clk);
        check("idle_abort", {5'b0, busy, in_ready, sr_load}, 8'h02);
        abort    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);

        send_frame(8'hC3, 1'b0, 1'b0, 8'h00, -1, 4);
        send_frame(8'hA5, 1'b0, 1'b0, 8'h00, -1, -1);

        for (int k = 0; k < 6; k++) begin
            rb = 8'($urandom_range(0, 255));
            rl = 1'($urandom_range(0, 1));
            send_frame(rb, rl, 1'b0, 8'h00, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
